// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter and its neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: arbiter state encoding and the default requester/hold limits
// that the downstream one-hot encoder bench also relies on.
package rr_grant_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_REQ  = 4;   // grant width expected by the 4-to-2 encoder
   localparam int DEF_MAX_HOLD = 8;   // hold limit while others wait; 0 = never preempt
   localparam int DEF_CNT_W    = 4;   // hold counter width, 2^CNT_W > MAX_HOLD

endpackage

// File: rtl/rr_grant_arbiter_pick.sv
// Rotate-priority selector: first set bit of cand after last_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; win is all-zero when cand is empty.
// Ports: cand (candidate vector), last_ptr (previous winner index),
//        win (one-hot winner), win_idx (winner index for pointer update).
module rr_pick
   import rr_grant_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] cand,
   input  logic [PTR_W-1:0]   last_ptr,
   output logic [NUM_REQ-1:0] win,
   output logic [PTR_W-1:0]   win_idx
);

   int   pos;
   logic found;

   // Walk the positions last_ptr+1 .. last_ptr+NUM_REQ (mod NUM_REQ); the
   // previous winner is therefore examined last.
   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      pos     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos = (int'(last_ptr) + k) % NUM_REQ;
         if (!found && cand[pos[PTR_W-1:0]]) begin
            found                 = 1'b1;
            win[pos[PTR_W-1:0]]   = 1'b1;
            win_idx               = pos[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant and bounded hold time.
// Latency: one cycle from req to grant; winner switch on release has no idle cycle.
// Backpressure: a winner keeps its grant while req stays high, up to MAX_HOLD
//               cycles when another requester is waiting (then preempt pulses).
// Ports: clk, rst_n (async active-low), req[NUM_REQ], grant[NUM_REQ] (one-hot
//        or zero), grant_valid (= |grant), preempt (one-cycle timeout pulse).
module rr_grant_arbiter
   import rr_grant_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic               preempt
);

   localparam int               PTR_W     = $clog2(NUM_REQ);
   localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               grant_valid_q, grant_valid_d;
   logic               preempt_q, preempt_d;
   logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

   logic [NUM_REQ-1:0] cand;
   logic [NUM_REQ-1:0] pick_win;
   logic [PTR_W-1:0]   pick_idx;
   logic               held;
   logic               others;
   logic               timeout;

   assign held    = |(req & grant_q);
   assign others  = |(req & ~grant_q);
   assign timeout = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

   // While the current winner still holds, only the other requesters are
   // eligible (preemption); otherwise everyone asking competes.
   assign cand = ((state_q == GRANT) && held) ? (req & ~grant_q) : req;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .cand     (cand),
      .last_ptr (last_ptr_q),
      .win      (pick_win),
      .win_idx  (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_ptr_d = last_ptr_q;
      hold_cnt_d = hold_cnt_q;
      preempt_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d    = pick_win;
               last_ptr_d = pick_idx;
               hold_cnt_d = '0;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            if (!held) begin
               // Release: hand straight over, or fall back to idle.
               hold_cnt_d = '0;
               if (|req) begin
                  grant_d    = pick_win;
                  last_ptr_d = pick_idx;
               end else begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end else if (timeout && others) begin
               grant_d    = pick_win;
               last_ptr_d = pick_idx;
               hold_cnt_d = '0;
               preempt_d  = 1'b1;
            end else if (hold_cnt_q != CNT_SAT) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase

      grant_valid_d = |grant_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         preempt_q     <= 1'b0;
         last_ptr_q    <= PTR_RST;
         hold_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         preempt_q     <= preempt_d;
         last_ptr_q    <= last_ptr_d;
         hold_cnt_q    <= hold_cnt_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random traffic, all
// checked against a behavioural round-robin model through a scoreboard queue.
// Inputs change on the falling edge; outputs are sampled just after the rising edge.
module tb_rr_grant_arbiter;
   import rr_grant_arbiter_pkg::*;

   localparam int N       = DEF_NUM_REQ;
   localparam int MH      = DEF_MAX_HOLD;
   localparam int CNT_SAT = (1 << DEF_CNT_W) - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic         preempt;

   always #5 clk = ~clk;

   rr_grant_arbiter #(
      .NUM_REQ  (N),
      .MAX_HOLD (MH),
      .CNT_W    (DEF_CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_valid (grant_valid),
      .preempt     (preempt)
   );

   typedef struct {
      logic [N-1:0] grant;
      logic         vld;
      logic         pre;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference model: who holds the grant (-1 = nobody), who was served
   // last, and how many consecutive edges the holder has kept it.
   int m_cur;
   int m_last;
   int m_hold;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   function automatic int pick(input logic [N-1:0] c, input int last);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (last + k) % N;
         if (((c >> i) & 1) != 0) return i;
      end
      return -1;
   endfunction

   function automatic int enc(input logic [N-1:0] g);
      for (int i = 0; i < N; i++)
         if (((g >> i) & 1) != 0) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_cur  = -1;
      m_last = N - 1;
      m_hold = 0;
   endtask

   task automatic model_step(input logic [N-1:0] r, output exp_t e);
      logic [N-1:0] rest;
      logic         pre;
      pre = 1'b0;
      if (m_cur < 0) begin
         if (r != 0) begin
            m_cur  = pick(r, m_last);
            m_last = m_cur;
            m_hold = 0;
         end
      end else if (((r >> m_cur) & 1) == 0) begin
         m_cur  = pick(r, m_last);
         if (m_cur >= 0) m_last = m_cur;
         m_hold = 0;
      end else begin
         rest = r & ~(N'(1) << m_cur);
         if (MH != 0 && m_hold == MH - 1 && rest != 0) begin
            m_cur  = pick(rest, m_last);
            m_last = m_cur;
            m_hold = 0;
            pre    = 1'b1;
         end else if (m_hold < CNT_SAT) begin
            m_hold++;
         end
      end
      e.grant = (m_cur >= 0) ? (N'(1) << m_cur) : '0;
      e.vld   = (m_cur >= 0);
      e.pre   = pre;
   endtask

   // Drive one cycle of req, queue its expected outcome, return just after
   // the edge that consumed it.
   task automatic step(input logic [N-1:0] r);
      exp_t e;
      @(negedge clk);
      req = r;
      model_step(r, e);
      sb_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   // Scoreboard monitor.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_grant", grant, e.grant);
            chk("sb_valid", grant_valid, e.vld);
            chk("sb_preempt", preempt, e.pre);
            chk("inv_onehot", ($countones(grant) <= 1), 1'b1);
            chk("inv_valid_or", grant_valid, |grant);
         end
      end
   end

   initial begin
      int           cnt;
      int           guard;
      int           bad;
      logic [N-1:0] r;
      exp_t         e;

      rst_n = 1'b0;
      req   = '0;
      model_reset();
      #12;
      chk("reset_grant", grant, 0);
      chk("reset_valid", grant_valid, 0);
      chk("reset_preempt", preempt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request, one-cycle latency, encoder view.
      step('0);
      step(4'b0100);
      chk("single_grant", grant, 4'b0100);
      chk("single_valid", grant_valid, 1);
      chk("single_enc", enc(grant), 2);
      step('0);
      chk("release_idle", grant, 0);

      // Wrap past bit 3 to bit 0.
      step(4'b1000);
      chk("wrap_setup", grant, 4'b1000);
      step('0);
      step(4'b1001);
      chk("wrap_grant", grant, 4'b0001);
      step('0);

      // Rotation from the reset pointer, each winner dropping after 2 cycles.
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         r = '1;
         if (m_cur >= 0 && m_hold == 1) r = r & ~(N'(1) << m_cur);
         step(r);
         chk($sformatf("rotation[%0d]", c), grant, N'(1) << ((c / 2) % N));
      end
      step('0);
      step('0);

      // Preemption: bit 0 held exactly MAX_HOLD cycles, then bit 1.
      step(4'b0011);
      cnt   = 0;
      guard = 0;
      while (grant == 4'b0001 && guard < 20) begin
         cnt++;
         guard++;
         step(4'b0011);
      end
      chk("preempt_hold_cycles", cnt, MH);
      chk("preempt_grant", grant, 4'b0010);
      chk("preempt_pulse", preempt, 1);
      step(4'b0011);
      chk("preempt_one_cycle", preempt, 0);
      chk("preempt_after_grant", grant, 4'b0010);
      step('0);
      step('0);

      // Lone requester is never preempted.
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         step(4'b0100);
         if (grant !== 4'b0100 || preempt !== 1'b0) bad++;
      end
      chk("alone_bad_cycles", bad, 0);
      step('0);

      // Asynchronous reset in the middle of a grant.
      step(4'b0010);
      chk("async_setup", grant, 4'b0010);
      step(4'b0010);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_grant", grant, 0);
      chk("async_valid", grant_valid, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b0010;
      model_step(4'b0010, e);
      sb_q.push_back(e);
      @(posedge clk);
      #2;
      chk("post_reset_grant", grant, 4'b0010);

      // Random traffic with sticky requests so holds and timeouts occur.
      r = 4'b0010;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
         if (m_cur >= 0 && $urandom_range(0, 7) == 0) r = r & ~(N'(1) << m_cur);
         step(r);
      end
      step('0);
      chk("sb_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter for NUM_REQ requesters; produces a registered one-hot grant vector.
- Sits directly upstream of the 4-to-2 one-hot encoder: the grant output feeds the encoder, which converts it to a binary index.
- A grant is held while the winner keeps its request high, bounded by a hold timeout so other requesters are not starved.

Parameters:
- NUM_REQ, 4, number of requesters; grant width (the downstream encoder needs 4).
- MAX_HOLD, 8, maximum consecutive grant cycles while another request is pending; 0 disables preemption.
- CNT_W, 4, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  request lines, level-sensitive, bit i = requester i.
- grant  output  NUM_REQ  registered grant, always one-hot or all-zero.
- grant_valid  output  1  registered; high exactly when grant is nonzero.
- preempt  output  1  registered one-cycle pulse when a grant was removed by timeout.

Behaviour:
- Reset (async assert, sync release): grant=0, grant_valid=0, preempt=0, state IDLE, last_ptr=NUM_REQ-1 (first search starts at bit 0), hold_cnt=0.
- Selection function: first set bit of the candidate vector, searching from (last_ptr+1) mod NUM_REQ upward and wrapping to bit 0. It is purely combinational.
- States:
  - IDLE: grant=0.
  - GRANT: grant holds one bit.
- IDLE:
  - If req != 0, at the next edge load grant with the selection over req, set last_ptr to the winner, clear hold_cnt, and go to GRANT.
  - Latency is one cycle from req to grant.
- GRANT, release (req[winner]==0 at the edge): re-arbitrate over req in the same edge.
  - Another request present: grant switches directly to the new winner with no idle cycle, last_ptr updates, hold_cnt clears.
  - No other request: grant=0 and state returns to IDLE.
- GRANT, hold (req[winner]==1): hold_cnt increments, saturating at 2^CNT_W-1.
- GRANT, preemption: fires at the edge where MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, and (req & ~grant) != 0.
  - Grant moves to the selection over req & ~grant and last_ptr updates.
  - hold_cnt clears and preempt pulses for one cycle.
  - The preempted requester may win again later in normal round-robin order.
- Timeout with no other requester pending: grant is kept; hold_cnt keeps saturating with no preemption.
- Fairness: after requester i is served, priority order becomes i+1 .. NUM_REQ-1, 0 .. i.
- Invariants, checked every cycle:
  - grant is never multi-hot.
  - grant_valid == |grant.
  - grant[i] is set only if req[i] was high at the edge that asserted it.
- Reset mid-grant: grant drops asynchronously to 0 and the pointer returns to its reset value.
- Requests that pulse high and low between edges are not seen. The block does not sample asynchronously.

Decomposition:
- Shared package:
  - State encoding (IDLE=1'b0, GRANT=1'b1).
  - Default NUM_REQ and MAX_HOLD constants, shared with the encoder testbench.
- One sub-module, rr_pick: combinational rotate-priority selector.
  - Inputs: candidate vector and last_ptr.
  - Output: one-hot winner plus its index for pointer update.
  - Instantiated once in the arbiter.

Test Plan:
- Reset then single request: req=4'b0100 from cycle 2 -> grant=4'b0100 and grant_valid=1 at cycle 3; the downstream encoder reads 2'b10.
- Round-robin rotation: req=4'b1111, each winner drops its req after 2 grant cycles -> grant sequence 0001, 0010, 0100, 1000, 0001 with no idle gap.
- Wrap from pointer: last winner bit 3, then req=4'b1001 -> grant=4'b0001, because the search wraps past bit 3 to bit 0.
- Preemption: req=4'b0011 held constant with MAX_HOLD=8 -> bit 0 granted for exactly 8 cycles, then grant=4'b0010 with preempt=1 for one cycle.
- No preemption when alone: req=4'b0100 held for 20 cycles -> grant stays 4'b0100 and preempt never pulses.
- Async reset mid-grant: rst_n low between edges while grant=4'b0010 -> grant=0 and grant_valid=0 immediately; after release with req=4'b0010, grant=4'b0001 is not issued and grant=4'b0010 is issued at the next edge.
